// File: rtl/hazard_pkg.sv
// Shared widths and forwarding-select encoding for the decode hazard unit.
// Holds types and constants only; it contains no logic, latency or backpressure.
package hazard_pkg;

    localparam int AW    = 5;
    localparam int DW    = 128;
    localparam int LAT_W = 4;

    typedef enum logic [2:0] {
        SEL_RF,
        SEL_EX,
        SEL_MEM_ALU,
        SEL_MEM_LD,
        SEL_WB
    } fwdSel_e;

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding mux, priority EX > MEM > WB > register file; x0 is always read from RF.
// Purely combinational: zero latency and no backpressure of its own.
module fwd_src_sel
    import hazard_pkg::*;
#(
    parameter int AW = hazard_pkg::AW,
    parameter int DW = hazard_pkg::DW
) (
    input  logic [AW-1:0] rsAddr,
    input  logic [DW-1:0] rfData,
    input  logic [AW-1:0] exRdAddr,
    input  logic          exRdWen,
    input  logic [DW-1:0] exData,
    input  logic [AW-1:0] memRdAddr,
    input  logic          memRdWen,
    input  logic          memLdEn,
    input  logic [DW-1:0] memAluData,
    input  logic [DW-1:0] memLdData,
    input  logic [AW-1:0] wbRdAddr,
    input  logic          wbRdWen,
    input  logic [DW-1:0] wbData,
    output logic [DW-1:0] rsData
);

    fwdSel_e sel;

    always_comb begin
        sel = SEL_RF;
        if (rsAddr == '0) begin
            sel = SEL_RF;
        end else if (exRdWen && (exRdAddr == rsAddr)) begin
            sel = SEL_EX;
        end else if (memRdWen && (memRdAddr == rsAddr)) begin
            sel = memLdEn ? SEL_MEM_LD : SEL_MEM_ALU;
        end else if (wbRdWen && (wbRdAddr == rsAddr)) begin
            sel = SEL_WB;
        end
    end

    always_comb begin
        rsData = rfData;
        case (sel)
            SEL_EX:      rsData = exData;
            SEL_MEM_ALU: rsData = memAluData;
            SEL_MEM_LD:  rsData = memLdData;
            SEL_WB:      rsData = wbData;
            default:     rsData = rfData;
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode hazard unit: operand forwarding plus a per-register latency scoreboard that raises stall_req.
// Outputs are combinational in the same cycle; ext_stall freezes the scoreboard. SB_WAW_CHECK_EN adds WAW stalls.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int AW      = hazard_pkg::AW,
    parameter int DW      = hazard_pkg::DW,
    parameter int LAT_W   = hazard_pkg::LAT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dec_valid,
    input  logic [NUM_SRC*AW-1:0]  dec_rs_addr,
    input  logic [NUM_SRC-1:0]     dec_rs_en,
    input  logic [AW-1:0]          dec_rd_addr,
    input  logic                   dec_rd_wen,
    input  logic [LAT_W-1:0]       dec_lat,
    input  logic                   ext_stall,
    input  logic [NUM_SRC*DW-1:0]  rf_rs_data,
    input  logic [AW-1:0]          ex_rd_addr,
    input  logic                   ex_rd_wen,
    input  logic [DW-1:0]          ex_data,
    input  logic [AW-1:0]          mem_rd_addr,
    input  logic                   mem_rd_wen,
    input  logic                   mem_ld_en,
    input  logic [DW-1:0]          mem_alu_data,
    input  logic [DW-1:0]          mem_ld_data,
    input  logic [AW-1:0]          wb_rd_addr,
    input  logic                   wb_rd_wen,
    input  logic [DW-1:0]          wb_data,
    output logic                   stall_req,
    output logic [NUM_SRC*DW-1:0]  rs_data,
    output logic [(2**AW)-1:0]     busy_vec
);

    localparam int NREG = 2 ** AW;

    logic [LAT_W-1:0] cnt [NREG];
    logic             rawHit;
    logic             wawHit;
    logic             issue;
    logic             loadEn;

    always_comb begin
        rawHit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (dec_rs_en[i] && (dec_rs_addr[i*AW +: AW] != '0)
                && (cnt[dec_rs_addr[i*AW +: AW]] != '0)) begin
                rawHit = 1'b1;
            end
        end
    end

`ifdef SB_WAW_CHECK_EN
    assign wawHit = dec_rd_wen && (dec_rd_addr != '0) && (cnt[dec_rd_addr] != '0);
    // A zero-latency writer finds its counter already clear, so it need not load.
    assign loadEn = issue && dec_rd_wen && (dec_lat != '0);
`else
    assign wawHit = 1'b0;
    assign loadEn = issue && dec_rd_wen;
`endif

    assign stall_req = dec_valid && (rawHit || wawHit);
    assign issue     = dec_valid && !stall_req && !ext_stall;

    // cnt[0] is only ever written by reset, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else if (!ext_stall) begin
            for (int r = 1; r < NREG; r++) begin
                if (loadEn && (dec_rd_addr == AW'(r))) begin
                    cnt[r] <= dec_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        fwd_src_sel #(
            .AW (AW),
            .DW (DW)
        ) uFwd (
            .rsAddr     (dec_rs_addr[i*AW +: AW]),
            .rfData     (rf_rs_data[i*DW +: DW]),
            .exRdAddr   (ex_rd_addr),
            .exRdWen    (ex_rd_wen),
            .exData     (ex_data),
            .memRdAddr  (mem_rd_addr),
            .memRdWen   (mem_rd_wen),
            .memLdEn    (mem_ld_en),
            .memAluData (mem_alu_data),
            .memLdData  (mem_ld_data),
            .wbRdAddr   (wb_rd_addr),
            .wbRdWen    (wb_rd_wen),
            .wbData     (wb_data),
            .rsData     (rs_data[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic, checked against a ready-time model.
module tb_hazard_scoreboard;

    localparam int NUM_SRC = 3;
    localparam int AW      = 5;
    localparam int DW      = 128;
    localparam int LAT_W   = 4;
    localparam int NREG    = 2 ** AW;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  dec_valid;
    logic [NUM_SRC*AW-1:0] dec_rs_addr;
    logic [NUM_SRC-1:0]    dec_rs_en;
    logic [AW-1:0]         dec_rd_addr;
    logic                  dec_rd_wen;
    logic [LAT_W-1:0]      dec_lat;
    logic                  ext_stall;
    logic [NUM_SRC*DW-1:0] rf_rs_data;
    logic [AW-1:0]         ex_rd_addr;
    logic                  ex_rd_wen;
    logic [DW-1:0]         ex_data;
    logic [AW-1:0]         mem_rd_addr;
    logic                  mem_rd_wen;
    logic                  mem_ld_en;
    logic [DW-1:0]         mem_alu_data;
    logic [DW-1:0]         mem_ld_data;
    logic [AW-1:0]         wb_rd_addr;
    logic                  wb_rd_wen;
    logic [DW-1:0]         wb_data;
    logic                  stall_req;
    logic [NUM_SRC*DW-1:0] rs_data;
    logic [NREG-1:0]       busy_vec;

    hazard_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .AW      (AW),
        .DW      (DW),
        .LAT_W   (LAT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_rs_addr  (dec_rs_addr),
        .dec_rs_en    (dec_rs_en),
        .dec_rd_addr  (dec_rd_addr),
        .dec_rd_wen   (dec_rd_wen),
        .dec_lat      (dec_lat),
        .ext_stall    (ext_stall),
        .rf_rs_data   (rf_rs_data),
        .ex_rd_addr   (ex_rd_addr),
        .ex_rd_wen    (ex_rd_wen),
        .ex_data      (ex_data),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_wen   (mem_rd_wen),
        .mem_ld_en    (mem_ld_en),
        .mem_alu_data (mem_alu_data),
        .mem_ld_data  (mem_ld_data),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_wen    (wb_rd_wen),
        .wb_data      (wb_data),
        .stall_req    (stall_req),
        .rs_data      (rs_data),
        .busy_vec     (busy_vec)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    // Model: a register is busy until the count of unfrozen clock edges reaches its ready time.
    longint tick;
    longint readyAt [NREG];

    task automatic checkVal(input string tag, input logic [383:0] got, input logic [383:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rndData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit regBusy(input int r);
        return (r != 0) && (readyAt[r] > tick);
    endfunction

    function automatic bit modelStall();
        bit haz = 0;
        for (int i = 0; i < NUM_SRC; i++)
            if (dec_rs_en[i] && regBusy(int'(dec_rs_addr[i*AW +: AW]))) haz = 1;
`ifdef SB_WAW_CHECK_EN
        if (dec_rd_wen && regBusy(int'(dec_rd_addr))) haz = 1;
`endif
        return dec_valid && haz;
    endfunction

    function automatic logic [DW-1:0] modelOperand(input int i);
        logic [AW-1:0] a = dec_rs_addr[i*AW +: AW];
        if (a == 0) return rf_rs_data[i*DW +: DW];
        if (ex_rd_wen && ex_rd_addr == a) return ex_data;
        if (mem_rd_wen && mem_rd_addr == a) return mem_ld_en ? mem_ld_data : mem_alu_data;
        if (wb_rd_wen && wb_rd_addr == a) return wb_data;
        return rf_rs_data[i*DW +: DW];
    endfunction

    task automatic modelReset();
        tick = 0;
        for (int r = 0; r < NREG; r++) readyAt[r] = 0;
    endtask

    // Called just after a falling edge with inputs set: check outputs, advance model, move to next falling edge.
    task automatic cycleCheck(input string tag);
        logic [NREG-1:0]       expBusy;
        logic [NUM_SRC*DW-1:0] expData;
        bit                    st;
        #1;
        st = modelStall();
        for (int r = 0; r < NREG; r++) expBusy[r] = regBusy(r);
        for (int i = 0; i < NUM_SRC; i++) expData[i*DW +: DW] = modelOperand(i);
        checkVal({tag, "_stall"}, 384'(stall_req), 384'(st));
        checkVal({tag, "_busy"}, 384'(busy_vec), 384'(expBusy));
        checkVal({tag, "_data"}, 384'(rs_data), 384'(expData));
        if (dec_valid && !st && !ext_stall && dec_rd_wen && dec_rd_addr != 0) begin
`ifdef SB_WAW_CHECK_EN
            if (dec_lat != 0) readyAt[dec_rd_addr] = tick + 1 + dec_lat;
`else
            readyAt[dec_rd_addr] = tick + 1 + dec_lat;
`endif
        end
        if (!ext_stall) tick++;
        @(negedge clk);
    endtask

    task automatic setIdle();
        dec_valid = 0; dec_rs_en = '0; dec_rs_addr = '0; dec_rd_wen = 0;
        dec_rd_addr = '0; dec_lat = '0; ext_stall = 0;
        ex_rd_wen = 0; mem_rd_wen = 0; mem_ld_en = 0; wb_rd_wen = 0;
        ex_rd_addr = '0; mem_rd_addr = '0; wb_rd_addr = '0;
        rf_rs_data = {rndData(), rndData(), rndData()};
        ex_data = rndData(); mem_alu_data = rndData(); mem_ld_data = rndData(); wb_data = rndData();
    endtask

    task automatic drain();
        setIdle();
        for (int k = 0; k < 16; k++) cycleCheck("drain");
    endtask

    task automatic issueOp(input int rd, input int lat);
        setIdle();
        dec_valid = 1; dec_rd_wen = 1; dec_rd_addr = AW'(rd); dec_lat = LAT_W'(lat);
        cycleCheck("issue");
    endtask

    task automatic dependOn(input int rs);
        setIdle();
        dec_valid = 1; dec_rs_en = 3'b001; dec_rs_addr = (NUM_SRC*AW)'(rs);
    endtask

    // Runs cycles while stall_req is high; ext_stall is raised on the listed stall-cycle indices.
    task automatic countStalls(input string tag, input int frzA, input int frzB, output int n);
        n = 0;
        #1;
        while (stall_req && n < 30) begin
            ext_stall = (n == frzA) || (n == frzB);
            cycleCheck(tag);
            n++;
            #1;
        end
        ext_stall = 0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] d;
        modelReset();
        setIdle();
        rst_n = 0;
        dec_valid = 1; dec_rs_en = 3'b111; dec_rs_addr = {5'd3, 5'd2, 5'd1};
        #2;
        checkVal("reset_busy", 384'(busy_vec), 384'(0));
        checkVal("reset_stall", 384'(stall_req), 384'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        setIdle();
        cycleCheck("post_reset");

        // ALU result forwarded from EX the next cycle
        issueOp(5, 0);
        dependOn(5);
        ex_rd_addr = 5; ex_rd_wen = 1; d = ex_data;
        #1;
        checkVal("alu_ex_stall", 384'(stall_req), 384'(0));
        checkVal("alu_ex_fwd", 384'(rs_data[DW-1:0]), 384'(d));
        cycleCheck("alu");

        // Load-use: one bubble then MEM load data
        issueOp(7, 1);
        dependOn(7);
        mem_rd_addr = 7; mem_rd_wen = 1; mem_ld_en = 1; d = mem_ld_data;
        countStalls("ld", -1, -1, n);
        checkVal("ld_stall_cycles", 384'(n), 384'(1));
        checkVal("ld_fwd", 384'(rs_data[DW-1:0]), 384'(d));
        cycleCheck("ld_go");
        drain();

        // Latency-4 divide with a two-cycle freeze in the middle
        issueOp(9, 4);
        dependOn(9);
        wb_rd_addr = 9; wb_rd_wen = 1; d = wb_data;
        countStalls("div", 1, 2, n);
        checkVal("div_stall_cycles", 384'(n), 384'(6));
        checkVal("div_wb_fwd", 384'(rs_data[DW-1:0]), 384'(d));
        cycleCheck("div_go");
        drain();

        // x0 never forwards and never stalls
        dependOn(0);
        ex_rd_addr = 0; ex_rd_wen = 1;
        #1;
        checkVal("x0_stall", 384'(stall_req), 384'(0));
        checkVal("x0_rf", 384'(rs_data[DW-1:0]), 384'(rf_rs_data[DW-1:0]));
        cycleCheck("x0");

        // Write-after-write to x3
        issueOp(3, 3);
        setIdle();
        dec_valid = 1; dec_rd_wen = 1; dec_rd_addr = 3; dec_lat = 0;
        #1;
        checkVal("waw_busy3", 384'(busy_vec[3]), 384'(1));
        countStalls("waw", -1, -1, n);
`ifdef SB_WAW_CHECK_EN
        checkVal("waw_stall_cycles", 384'(n), 384'(3));
`else
        checkVal("waw_stall_cycles", 384'(n), 384'(0));
`endif
        cycleCheck("waw_go");
        setIdle();
        #1;
        checkVal("waw_busy3_clear", 384'(busy_vec[3]), 384'(0));
        cycleCheck("waw_after");
        drain();

        // Reset arriving mid-countdown
        issueOp(4, 3);
        setIdle();
        cycleCheck("cnt_down");
        dependOn(4);
        #1;
        checkVal("pre_rst_stall", 384'(stall_req), 384'(1));
        checkVal("pre_rst_busy4", 384'(busy_vec[4]), 384'(1));
        rst_n = 0;
        #1;
        checkVal("rst_busy", 384'(busy_vec), 384'(0));
        checkVal("rst_stall", 384'(stall_req), 384'(0));
        modelReset();
        @(negedge clk);
        rst_n = 1;
        cycleCheck("after_rst");

        // Random traffic over a small register window to provoke hits and hazards
        for (int k = 0; k < 600; k++) begin
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_rs_en   = NUM_SRC'($urandom);
            dec_rs_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            dec_rd_wen  = $urandom_range(0, 1) == 1;
            dec_rd_addr = AW'($urandom_range(0, 7));
            dec_lat     = ($urandom_range(0, 2) == 0) ? LAT_W'($urandom_range(2, 6)) : LAT_W'($urandom_range(0, 1));
            ext_stall   = ($urandom_range(0, 6) == 0);
            rf_rs_data  = {rndData(), rndData(), rndData()};
            ex_rd_addr  = AW'($urandom_range(0, 7));  ex_rd_wen  = $urandom_range(0, 1) == 1;
            mem_rd_addr = AW'($urandom_range(0, 7));  mem_rd_wen = $urandom_range(0, 1) == 1;
            mem_ld_en   = $urandom_range(0, 1) == 1;
            wb_rd_addr  = AW'($urandom_range(0, 7));  wb_rd_wen  = $urandom_range(0, 1) == 1;
            ex_data = rndData(); mem_alu_data = rndData(); mem_ld_data = rndData(); wb_data = rndData();
            cycleCheck("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised decode-stage hazard unit that supersedes the fixed three-operand forwarding block. It resolves every decode source operand from the EX, MEM (ALU or load), WB or register-file path. A per-register latency scoreboard tracks in-flight loads and multi-cycle producers (mul/div/SIMD), so the block stalls exactly until a result reaches a forwarding port. Sits between Decode/RF read and the ID/EX pipeline register.

## Interface
Parameters:
- NUM_SRC, 3, source operands per instruction
- AW, 5, register address width (2**AW registers; register 0 hardwired zero)
- DW, 128, operand data width
- LAT_W, 4, producer latency counter width (max latency 2**LAT_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dec_valid  in  1  decode holds a valid instruction
- dec_rs_addr  in  NUM_SRC*AW  source addresses, source i at [i*AW +: AW]
- dec_rs_en  in  NUM_SRC  source i is actually read
- dec_rd_addr  in  AW  destination address
- dec_rd_wen  in  1  instruction writes rd
- dec_lat  in  LAT_W  producer latency: 0 ALU, 1 load, L>1 multi-cycle unit
- ext_stall  in  1  downstream freeze
- rf_rs_data  in  NUM_SRC*DW  register-file read data
- ex_rd_addr / ex_rd_wen / ex_data  in  AW / 1 / DW  EX-stage result
- mem_rd_addr / mem_rd_wen / mem_ld_en  in  AW / 1 / 1  MEM-stage destination and load flag
- mem_alu_data / mem_ld_data  in  DW / DW  MEM ALU result / D-cache read data
- wb_rd_addr / wb_rd_wen / wb_data  in  AW / 1 / DW  write-back result, including multi-cycle unit results
- stall_req  out  1  hold decode this cycle
- rs_data  out  NUM_SRC*DW  resolved operands
- busy_vec  out  2**AW  scoreboard nonzero flags, for debug

## Operation
- Issue = dec_valid & ~stall_req & ~ext_stall.
- Scoreboard: cnt[r] is LAT_W wide, one per register; cnt[0] is constant 0.
- On issue with dec_rd_wen, rd!=0 and dec_lat>=1: cnt[rd] <= dec_lat. A dec_lat of 0 leaves cnt[rd] unchanged, because the WAW stall guarantees it is already 0.
- Every cycle without ext_stall, every nonzero counter that is not being loaded decrements by 1. If a counter is loaded and decremented in the same cycle, the load wins.
- With ext_stall, all counters hold.
- Producer contract:
  - A load issued at cycle N is in MEM at N+2, when cnt reaches 0.
  - A multi-cycle producer drives wb_* in the cycle its counter reaches 0.
- Forwarding per source i, priority order:
  - addr==0 → RF
  - ex hit → ex_data
  - mem hit → mem_ld_data if mem_ld_en, else mem_alu_data
  - wb hit → wb_data
  - otherwise → RF
  - A "hit" means wen=1 and the addresses are equal.
- RAW stall: any i with dec_rs_en[i], addr!=0 and cnt[addr]!=0.
- WAW stall (when configured): dec_rd_wen, rd!=0 and cnt[rd]!=0.
- stall_req = dec_valid & (RAW | WAW). It is independent of ext_stall.

## Timing
- rs_data and stall_req are combinational from the inputs and the scoreboard, in the same cycle.
- Scoreboard updates on the rising clk edge.
- Load-use: exactly 1 stall cycle. Latency-L producer: L stall cycles for an immediate dependent.
- Reset: asynchronous clear of all counters.
  - stall_req=0 and busy_vec=0 immediately, including when reset arrives mid-countdown.
  - rs_data follows the forwarding mux.
- Re-issue to a register while its counter is nonzero is impossible with the WAW check, because that case stalls.

## Configuration
- SB_WAW_CHECK_EN defined: WAW stall as above.
- SB_WAW_CHECK_EN undefined:
  - No WAW stall; a later issue overwrites cnt[rd] with its dec_lat, including overwriting with 0 when dec_lat=0.
  - Software or the compiler must guarantee ordering.

## Structure
- Package hazard_pkg holds:
  - forward select encoding: SEL_RF, SEL_EX, SEL_MEM_ALU, SEL_MEM_LD, SEL_WB
  - default widths: AW, DW, LAT_W
- Sub-module fwd_src_sel: one instance per source, generated NUM_SRC times. It computes the select and muxes the data.
- The scoreboard and stall logic stay in the top module.

## Test plan
- After reset, issue ALU to x5 (lat 0), next cycle source x5 → rs_data=ex_data, stall_req=0.
- Load to x7 (lat 1), dependent next cycle on x7 → stall_req=1 for 1 cycle, then rs_data=mem_ld_data with mem_ld_en=1.
- Div to x9 (lat 4), dependent next → 4 stall cycles; with ext_stall high 2 cycles mid-countdown → 6 stall cycles, then wb_data forwarded.
- Source x0 with ex_rd_addr=0 and ex_rd_wen=1 → rs_data=rf_rs_data, never stalls.
- Lat-3 op to x3, then ALU to x3 → stall 3 cycles with SB_WAW_CHECK_EN; without it no stall and busy_vec[3] clears next edge.
- rst_n low while cnt[4]=2 → busy_vec=0 and stall_req=0 in the same cycle.
